// File: rtl/mano_pkg.sv
`default_nettype none
// ============================================================================
// mano_pkg : shared widths and the 3-to-8 one-hot decoder for T and D
// Revision : 1.0
// ============================================================================
package mano_pkg;

  localparam int WORD_W  = 16;
  localparam int SC_W    = 3;
  localparam int T_W     = 8;
  localparam int OPC_LSB = 12;
  localparam int I_BIT   = 15;

  function automatic logic [T_W-1:0] decode3to8(input logic [SC_W-1:0] v);
    logic [T_W-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
// seq_counter : 3-bit sequence counter SC with clear/increment/hold and S gating
// Revision    : 1.0
// ============================================================================
module seq_counter
  import mano_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  input  logic            hlt,
  input  logic            start,
  input  logic            clr,
  output logic [SC_W-1:0] sc,
  output logic [T_W-1:0]  t
);

  logic [SC_W-1:0] r_sc;

  // A halt freezes SC on the very edge that drops S, so the halted step is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sc <= '0;
    end else if (hlt) begin
      r_sc <= r_sc;
    end else if (!run) begin
      if (start) begin
        r_sc <= '0;
      end
    end else if (clr) begin
      r_sc <= '0;
    end else begin
      r_sc <= r_sc + 1'b1;
    end
  end

  assign sc = r_sc;
  assign t  = run ? decode3to8(r_sc) : '0;

endmodule
`default_nettype wire

// File: rtl/timing_decode.sv
`default_nettype none
// ============================================================================
// timing_decode : run control, IR, opcode decode and interrupt-cycle control
// Revision      : 1.0
// ============================================================================
module timing_decode
  import mano_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              start,
  input  logic              hlt,
  input  logic              sc_clr,
  input  logic              ien_set,
  input  logic              ien_clr,
  input  logic              fgi,
  input  logic              fgo,
  output logic [T_W-1:0]    T,
  output logic [T_W-1:0]    D,
  output logic [WORD_W-1:0] B,
  output logic              I,
  output logic              R,
  output logic              IEN,
  output logic              S
);

  logic [WORD_W-1:0] r_ir;
  logic [T_W-1:0]    r_d;
  logic              r_i;
  logic              r_r;
  logic              r_ien;
  logic              r_s;

  logic [SC_W-1:0]   w_sc;
  logic [T_W-1:0]    w_t;
  logic              w_int_end;
  logic              w_int_req;
  logic              w_sc_clr;

  assign w_int_end = r_r & w_t[2];
  assign w_int_req = r_s & (w_sc >= SC_W'(3)) & r_ien & (fgi | fgo);
  assign w_sc_clr  = sc_clr | w_int_end;

  seq_counter u_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (r_s),
    .hlt     (hlt),
    .start   (start),
    .clr     (w_sc_clr),
    .sc      (w_sc),
    .t       (w_t)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s <= 1'b0;
    end else if (hlt) begin
      r_s <= 1'b0;
    end else if (start) begin
      r_s <= 1'b1;
    end
  end

  // Fetch and decode are suppressed while the interrupt cycle owns T0..T2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir <= '0;
      r_d  <= '0;
      r_i  <= 1'b0;
    end else begin
      if (w_t[1] && !r_r) begin
        r_ir <= mem_data;
      end
      if (w_t[2] && !r_r) begin
        r_d <= decode3to8(r_ir[OPC_LSB +: 3]);
        r_i <= r_ir[I_BIT];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_r <= 1'b0;
    end else if (w_int_end) begin
      r_r <= 1'b0;
    end else if (w_int_req) begin
      r_r <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ien <= 1'b0;
    end else if (w_int_end || ien_clr) begin
      r_ien <= 1'b0;
    end else if (ien_set) begin
      r_ien <= 1'b1;
    end
  end

  assign T   = w_t;
  assign D   = r_d;
  assign B   = r_ir;
  assign I   = r_i;
  assign R   = r_r;
  assign IEN = r_ien;
  assign S   = r_s;

endmodule
`default_nettype wire

// File: tb/tb_timing_decode.sv
`default_nettype none
// ============================================================================
// tb_timing_decode : scoreboard bench for timing_decode
// Revision         : 1.0
// ============================================================================
module tb_timing_decode;

  localparam int SEL_T   = 0;
  localparam int SEL_D   = 1;
  localparam int SEL_B   = 2;
  localparam int SEL_I   = 3;
  localparam int SEL_R   = 4;
  localparam int SEL_IEN = 5;
  localparam int SEL_S   = 6;
  localparam int SEL_SC  = 7;

  logic        clk;
  logic        reset_n;
  logic [15:0] mem_data;
  logic        start, hlt, sc_clr, ien_set, ien_clr, fgi, fgo;
  logic [7:0]  T, D;
  logic [15:0] B;
  logic        I, R, IEN, S;

  typedef struct {
    int          cyc;
    int          sel;
    string       tag;
    logic [15:0] val;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       cyc;
  int       n_checks;
  int       n_errors;

  timing_decode dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mem_data (mem_data),
    .start    (start),
    .hlt      (hlt),
    .sc_clr   (sc_clr),
    .ien_set  (ien_set),
    .ien_clr  (ien_clr),
    .fgi      (fgi),
    .fgo      (fgo),
    .T        (T),
    .D        (D),
    .B        (B),
    .I        (I),
    .R        (R),
    .IEN      (IEN),
    .S        (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      SEL_T:   return {8'h00, T};
      SEL_D:   return {8'h00, D};
      SEL_B:   return B;
      SEL_I:   return {15'd0, I};
      SEL_R:   return {15'd0, R};
      SEL_IEN: return {15'd0, IEN};
      SEL_S:   return {15'd0, S};
      SEL_SC:  return {13'd0, dut.u_seq.sc};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Queue an expectation to be compared dly samples from now.
  task automatic expect_at(input int dly, input int sel, input string tag, input logic [15:0] v);
    sb_item_t it;
    it.cyc = cyc + dly;
    it.sel = sel;
    it.tag = tag;
    it.val = v;
    sb_q.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = sb_q.size() - 1; k >= 0; k--) begin
      if (sb_q[k].cyc == cyc) begin
        check_value(sb_q[k].tag, observe(sb_q[k].sel), sb_q[k].val);
        sb_q.delete(k);
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 0; hlt = 0; sc_clr = 0; ien_set = 0; ien_clr = 0; fgi = 0; fgo = 0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_errors = 0;
    reset_n = 1'b0; mem_data = 16'h0000;
    start = 0; hlt = 0; sc_clr = 0; ien_set = 0; ien_clr = 0; fgi = 0; fgo = 0;
    #3;
    check_value("rst_T",   {8'h00, T}, 16'h0000);
    check_value("rst_D",   {8'h00, D}, 16'h0000);
    check_value("rst_B",   B,          16'h0000);
    check_value("rst_I",   {15'd0, I}, 16'h0000);
    check_value("rst_R",   {15'd0, R}, 16'h0000);
    check_value("rst_IEN", {15'd0, IEN}, 16'h0000);
    check_value("rst_S",   {15'd0, S}, 16'h0000);
    tick();
    reset_n = 1'b1;
    expect_at(1, SEL_T, "idle_T", 16'h0000);
    tick();

    // T walks through all eight steps and wraps
    for (int k = 0; k < 8; k++) expect_at(k + 1, SEL_T, "t_walk", 16'(1 << k));
    expect_at(9, SEL_T, "t_wrap", 16'h0001);
    expect_at(1, SEL_S, "s_start", 16'h0001);
    start = 1; tick(); start = 0;
    repeat (8) tick();

    // Fetch/decode of F3A5, then an sc_clr at T3
    do_reset();
    mem_data = 16'hF3A5;
    expect_at(1, SEL_T, "f3_T0", 16'h0001);
    expect_at(2, SEL_T, "f3_T1", 16'h0002);
    expect_at(3, SEL_T, "f3_T2", 16'h0004);
    expect_at(3, SEL_B, "f3_B",  16'hF3A5);
    expect_at(4, SEL_T, "f3_T3", 16'h0008);
    expect_at(4, SEL_D, "f3_D",  16'h0080);
    expect_at(4, SEL_I, "f3_I",  16'h0001);
    expect_at(5, SEL_T, "f3_clrT", 16'h0001);
    expect_at(5, SEL_D, "f3_Dhold", 16'h0080);
    start = 1; tick(); start = 0;
    repeat (3) tick();
    sc_clr = 1; tick(); sc_clr = 0;
    expect_at(1, SEL_T, "f3_T1b", 16'h0002);
    tick();

    // Decode of 2123: opcode 2, direct
    do_reset();
    mem_data = 16'h2123;
    expect_at(3, SEL_B, "op2_B", 16'h2123);
    expect_at(4, SEL_T, "op2_T3", 16'h0008);
    expect_at(4, SEL_D, "op2_D", 16'h0004);
    expect_at(4, SEL_I, "op2_I", 16'h0000);
    start = 1; tick(); start = 0;
    repeat (3) tick();

    // IEN priority, then interrupt entry and exit
    do_reset();
    ien_set = 1; expect_at(1, SEL_IEN, "ien_set", 16'h0001); tick();
    ien_clr = 1; expect_at(1, SEL_IEN, "ien_both", 16'h0000); tick();
    ien_clr = 0; expect_at(1, SEL_IEN, "ien_reset", 16'h0001); tick();
    ien_set = 0;
    mem_data = 16'h1234;
    expect_at(4, SEL_D, "int_D", 16'h0002);
    expect_at(5, SEL_T, "int_T4", 16'h0010);
    expect_at(5, SEL_R, "int_R0", 16'h0000);
    start = 1; tick(); start = 0;
    repeat (4) tick();
    fgi = 1;
    expect_at(1, SEL_R, "int_Rset", 16'h0001);
    expect_at(1, SEL_T, "int_T5", 16'h0020);
    tick();
    fgi = 0; mem_data = 16'hFFFF;
    expect_at(1, SEL_T,   "int_T6", 16'h0040);
    expect_at(2, SEL_T,   "int_T7", 16'h0080);
    expect_at(3, SEL_T,   "int_RT0", 16'h0001);
    expect_at(3, SEL_R,   "int_Rhold", 16'h0001);
    expect_at(4, SEL_T,   "int_RT1", 16'h0002);
    expect_at(5, SEL_T,   "int_RT2", 16'h0004);
    expect_at(5, SEL_B,   "int_Bhold", 16'h1234);
    expect_at(5, SEL_D,   "int_Dhold", 16'h0002);
    expect_at(5, SEL_IEN, "int_IEN1", 16'h0001);
    expect_at(6, SEL_R,   "int_Rclr", 16'h0000);
    expect_at(6, SEL_IEN, "int_IENclr", 16'h0000);
    expect_at(6, SEL_T,   "int_T0", 16'h0001);
    expect_at(6, SEL_B,   "int_Bkeep", 16'h1234);
    expect_at(6, SEL_D,   "int_Dkeep", 16'h0002);
    repeat (6) tick();

    // Start while running ignored; hlt beats start; sc_clr ignored when halted
    do_reset();
    mem_data = 16'h0000;
    start = 1; tick(); start = 0;
    tick(); tick();
    start = 1; expect_at(1, SEL_T, "run_start_T3", 16'h0008); tick(); start = 0;
    tick(); tick();
    hlt = 1; start = 1;
    expect_at(1, SEL_S,  "hlt_S", 16'h0000);
    expect_at(1, SEL_T,  "hlt_T", 16'h0000);
    expect_at(1, SEL_SC, "hlt_SC", 16'h0005);
    tick();
    hlt = 0; start = 0; sc_clr = 1;
    expect_at(1, SEL_SC, "idle_clr_SC", 16'h0005);
    expect_at(1, SEL_T,  "idle_clr_T", 16'h0000);
    tick();
    sc_clr = 0; start = 1;
    expect_at(1, SEL_T, "restart_T0", 16'h0001);
    expect_at(1, SEL_S, "restart_S", 16'h0001);
    expect_at(2, SEL_T, "restart_T1", 16'h0002);
    tick(); start = 0;
    tick();

    // Asynchronous reset in the middle of T3
    do_reset();
    mem_data = 16'hF3A5;
    expect_at(4, SEL_D, "ar_D", 16'h0080);
    start = 1; tick(); start = 0;
    repeat (3) tick();
    ien_set = 1; tick(); ien_set = 0;
    #2;
    reset_n = 1'b0;
    #1;
    check_value("ar_T",   {8'h00, T}, 16'h0000);
    check_value("ar_D0",  {8'h00, D}, 16'h0000);
    check_value("ar_B",   B,          16'h0000);
    check_value("ar_I",   {15'd0, I}, 16'h0000);
    check_value("ar_S",   {15'd0, S}, 16'h0000);
    check_value("ar_IEN", {15'd0, IEN}, 16'h0000);
    tick();
    reset_n = 1'b1;
    expect_at(1, SEL_T, "ar_idle1", 16'h0000);
    expect_at(2, SEL_T, "ar_idle2", 16'h0000);
    expect_at(2, SEL_S, "ar_idleS", 16'h0000);
    repeat (2) tick();

    check_value("sb_drain", 16'(sb_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
